dram_clr: RTL

- Parametrised 1-read/1-write synchronous data RAM for the stack machine data path. It is the successor of the fixed 8x32 data RAM.
- Adds configurable width and depth, and an optional output register stage.
- Adds explicit read-valid signalling and same-address write-to-read forwarding.
- Adds a hardware clear sequencer that zero-fills the array after reset or on request, and reports busy while doing so.

---
 rtl/dram_clr.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dram_clr.sv
`default_nettype none
// ============================================================================
//  Module   : dram_clr
//  Purpose  : Parametrised 1-read/1-write synchronous data RAM for the stack
//             machine data path. Provides read-valid signalling, same-address
//             write-to-read forwarding, an optional output register stage and
//             a hardware clear sequencer that zero-fills the array after
//             reset or on request.
//  Ports    : clk        - system clock, rising edge
//             rst        - asynchronous active-high reset
//             ram_radr   - read address
//             ram_ren    - read request (sampled with ram_radr)
//             ram_rdata  - read data, qualified by ram_rvalid
//             ram_rvalid - ram_rdata holds the result of an accepted read
//             ram_wadr   - write address
//             ram_wdata  - write data
//             ram_wen    - write enable
//             clr_req    - request a full zero-fill (pulse or level)
//             busy       - clear sweep in progress; accesses are dropped
//  Revision : 1.0 - initial release
// ============================================================================
module dram_clr #(
   parameter int DATA_W  = 8,
   parameter int ADR_W   = 5,
   parameter int OUT_REG = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADR_W-1:0]  ram_radr,
   input  logic              ram_ren,
   output logic [DATA_W-1:0] ram_rdata,
   output logic              ram_rvalid,
   input  logic [ADR_W-1:0]  ram_wadr,
   input  logic [DATA_W-1:0] ram_wdata,
   input  logic              ram_wen,
   input  logic              clr_req,
   output logic              busy
);

   localparam int DEPTH = 1 << ADR_W;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADR_W-1:0]  cnt;
   logic [ADR_W-1:0]  cnt_nxt;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              idle;
   logic              rd_acc;
   logic              wr_acc;
   logic              fwd;
   logic              wr_en;
   logic [ADR_W-1:0]  wr_adr;
   logic [DATA_W-1:0] wr_data;

   logic [DATA_W-1:0] rdata_q;
   logic              rvalid_q;

   // ------------------------------------------------------------------------
   // Clear sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Terminal count is detected explicitly, so the counter wrapping back to
   // zero on the final sweep write never starts a second sweep.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_CLEAR: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == {ADR_W{1'b1}}) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (clr_req) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_CLEAR;
            cnt_nxt   = '0;
         end
      endcase
   end

   // busy decodes the state register only; clr_req has no path to it.
   assign busy   = (state == ST_CLEAR);
   assign idle   = (state == ST_IDLE);
   assign rd_acc = idle & ram_ren;
   assign wr_acc = idle & ram_wen;
   assign fwd    = wr_acc && (ram_wadr == ram_radr);

   // ------------------------------------------------------------------------
   // Single write port shared between user writes and the clear sweep
   // ------------------------------------------------------------------------
   assign wr_en   = busy | wr_acc;
   assign wr_adr  = busy ? cnt : ram_wadr;
   assign wr_data = busy ? '0  : ram_wdata;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_adr] <= wr_data;
      end
   end

   // ------------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------------
   generate
      if (OUT_REG == 0) begin : g_lat1
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rdata_q  <= '0;
               rvalid_q <= 1'b0;
            end else begin
               rvalid_q <= rd_acc;
               if (rd_acc) begin
                  rdata_q <= fwd ? ram_wdata : mem[ram_radr];
               end
            end
         end
      end else begin : g_lat2
         logic [DATA_W-1:0] ram_q;
         logic [DATA_W-1:0] fwd_data_q;
         logic              fwd_q;
         logic              v1_q;

         // Plain synchronous array read with no reset, so the array maps onto
         // block RAM; the forwarding decision is carried alongside it.
         always_ff @(posedge clk) begin
            if (rd_acc) begin
               ram_q <= mem[ram_radr];
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               fwd_q      <= 1'b0;
               fwd_data_q <= '0;
               v1_q       <= 1'b0;
            end else begin
               v1_q <= rd_acc;
               if (rd_acc) begin
                  fwd_q      <= fwd;
                  fwd_data_q <= ram_wdata;
               end
            end
         end

         // Reads captured in stage one complete even if a sweep has started.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rdata_q  <= '0;
               rvalid_q <= 1'b0;
            end else begin
               rvalid_q <= v1_q;
               if (v1_q) begin
                  rdata_q <= fwd_q ? fwd_data_q : ram_q;
               end
            end
         end
      end
   endgenerate

   assign ram_rdata  = rdata_q;
   assign ram_rvalid = rvalid_q;

endmodule
`default_nettype wire
